// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : legv8_ctrl_pkg
// Description : Shared definitions for the LEGv8 multi-cycle controller.
//               FSM state encoding, instruction classes, opcode values and
//               masks, aluOp encodings and an opcode match helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package legv8_ctrl_pkg;

  // Opcode field width; the opcode always sits in the top bits of the IR.
  localparam int c_OPC_W = 11;

  // Fully specified opcodes.
  localparam logic [c_OPC_W-1:0] c_OPC_ADD  = 11'b10001011000;
  localparam logic [c_OPC_W-1:0] c_OPC_SUB  = 11'b11001011000;
  localparam logic [c_OPC_W-1:0] c_OPC_AND  = 11'b10001010000;
  localparam logic [c_OPC_W-1:0] c_OPC_ORR  = 11'b10101010000;
  localparam logic [c_OPC_W-1:0] c_OPC_LDUR = 11'b11111000010;
  localparam logic [c_OPC_W-1:0] c_OPC_STUR = 11'b11111000000;

  // CBZ and B carry immediate bits inside the 11-bit opcode field, so they
  // are matched against a value under a mask.
  localparam logic [c_OPC_W-1:0] c_OPC_CBZ  = 11'b10110100000;
  localparam logic [c_OPC_W-1:0] c_MASK_CBZ = 11'b11111111000;
  localparam logic [c_OPC_W-1:0] c_OPC_B    = 11'b00010100000;
  localparam logic [c_OPC_W-1:0] c_MASK_B   = 11'b11111100000;

  // aluOp encodings.
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_PASSB = 2'b01;
  localparam logic [1:0] c_ALUOP_RTYPE = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_RTYPE   = 3'd1,
    CLS_LDUR    = 3'd2,
    CLS_STUR    = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_B       = 3'd5
  } instr_cls_e;

  function automatic logic opc_match(
    input logic [c_OPC_W-1:0] opc,
    input logic [c_OPC_W-1:0] value,
    input logic [c_OPC_W-1:0] mask
  );
    return (opc & mask) == value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_decoder.sv
`default_nettype none
// ============================================================================
// Module      : legv8_decoder
// Description : Combinational opcode decoder. Classifies the latched opcode
//               and produces the static controls that depend only on the
//               instruction (not on the FSM state).
// Ports       : opcode_i  - IR opcode field
//               cls_o     - instruction class
//               illegal_o - opcode is not decodable
//               reg2loc_o - second read port takes Rt instead of Rm
//               alu_op_o  - ALU operation class
//               alu_src_o - ALU B operand is the immediate
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_decoder
  import legv8_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  logic [c_OPC_W-1:0] opcode_i,
  output instr_cls_e         cls_o,
  output logic               illegal_o,
  output logic               reg2loc_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               alu_src_o
);

  always_comb begin
    cls_o     = CLS_ILLEGAL;
    reg2loc_o = 1'b0;
    alu_op_o  = ALUOP_W'(c_ALUOP_ADD);
    alu_src_o = 1'b0;

    if ((opcode_i == c_OPC_ADD) || (opcode_i == c_OPC_SUB) ||
        (opcode_i == c_OPC_AND) || (opcode_i == c_OPC_ORR)) begin
      cls_o    = CLS_RTYPE;
      alu_op_o = ALUOP_W'(c_ALUOP_RTYPE);
    end else if (opcode_i == c_OPC_LDUR) begin
      cls_o     = CLS_LDUR;
      alu_src_o = 1'b1;
    end else if (opcode_i == c_OPC_STUR) begin
      // Store data comes from Rt, so the second read port is steered to it.
      cls_o     = CLS_STUR;
      alu_src_o = 1'b1;
      reg2loc_o = 1'b1;
    end else if (opc_match(opcode_i, c_OPC_CBZ, c_MASK_CBZ)) begin
      // CBZ tests Rt for zero by passing it straight through the ALU.
      cls_o     = CLS_CBZ;
      reg2loc_o = 1'b1;
      alu_op_o  = ALUOP_W'(c_ALUOP_PASSB);
    end else if (opc_match(opcode_i, c_OPC_B, c_MASK_B)) begin
      cls_o = CLS_B;
    end
  end

  assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle LEGv8 control unit. Fetches an instruction over a
//               req/ack handshake into the IR, decodes it and steps the
//               datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//               Optional handshake timeout, stall freeze, illegal-op flag.
// Ports       : clk, rst_n            - clock, async active-low reset
//               imemReq/imemAck/instruction - instruction fetch handshake
//               dmemAck               - data access complete
//               aluZero               - ALU zero flag for CBZ
//               stall                 - freeze FSM and registers
//               reg2LocOut, unconditionalBranch, branch, memRead, memWrite,
//               memToReg, aluOP, aluSRC, regWrite - datapath controls
//               pcWrite, pcSrc        - PC update strobe and source select
//               readRegister1/2, writeRegister - register file addresses
//               illegalOp, timeoutErr - error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
  import legv8_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imemReq,
  input  logic                  imemAck,
  input  logic [INSTR_W-1:0]    instruction,
  input  logic                  dmemAck,
  input  logic                  aluZero,
  input  logic                  stall,
  output logic                  reg2LocOut,
  output logic                  unconditionalBranch,
  output logic                  branch,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  memToReg,
  output logic [ALUOP_W-1:0]    aluOP,
  output logic                  aluSRC,
  output logic                  regWrite,
  output logic                  pcWrite,
  output logic                  pcSrc,
  output logic [REG_ADDR_W-1:0] readRegister1,
  output logic [REG_ADDR_W-1:0] readRegister2,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic                  illegalOp,
  output logic                  timeoutErr
);

  localparam int c_WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [c_WAIT_W-1:0] wait_q, wait_d;
  // Low until the first clock after reset release so that imemReq does not
  // assert while reset is still being released.
  logic                run_q;

  instr_cls_e          w_cls;
  logic                w_illegal;
  logic                w_reg2loc;
  logic [ALUOP_W-1:0]  w_dec_alu_op;
  logic                w_dec_alu_src;

  logic                w_timeout;
  logic [c_WAIT_W-1:0] w_wait_inc;

  logic                w_imem_req;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_mem_to_reg;
  logic                w_branch;
  logic                w_uncond;
  logic                w_pc_src;
  logic [ALUOP_W-1:0]  w_alu_op;
  logic                w_alu_src;
  logic                w_reg_write;
  logic                w_pc_write;
  logic                w_illegal_p;
  logic                w_timeout_p;

  // Shamt and immediate fields are consumed by the datapath, not here.
  logic                w_unused_ir;
  assign w_unused_ir = ^ir_q;

  legv8_decoder #(
    .ALUOP_W (ALUOP_W)
  ) u_decoder (
    .opcode_i  (ir_q[INSTR_W-1 -: c_OPC_W]),
    .cls_o     (w_cls),
    .illegal_o (w_illegal),
    .reg2loc_o (w_reg2loc),
    .alu_op_o  (w_dec_alu_op),
    .alu_src_o (w_dec_alu_src)
  );

  // The counter only runs when a timeout is configured; since the timeout
  // fires on equality it never needs to saturate.
  assign w_timeout  = (MEM_TIMEOUT != 0) && (wait_q == c_TIMEOUT);
  assign w_wait_inc = (MEM_TIMEOUT != 0) ? (wait_q + c_WAIT_W'(1)) : wait_q;

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    wait_d       = wait_q;
    w_imem_req   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_uncond     = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_op     = '0;
    w_alu_src    = 1'b0;
    w_reg_write  = 1'b0;
    w_pc_write   = 1'b0;
    w_illegal_p  = 1'b0;
    w_timeout_p  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          if (w_timeout) begin
            // Drop the request for a cycle and retry; the PC is untouched.
            w_timeout_p = 1'b1;
            wait_d      = '0;
          end else begin
            w_imem_req = 1'b1;
            if (imemAck) begin
              ir_d    = instruction;
              wait_d  = '0;
              state_d = ST_DECODE;
            end else begin
              wait_d = w_wait_inc;
            end
          end
        end
      end

      ST_DECODE: begin
        if (w_illegal) begin
          w_illegal_p = 1'b1;
          w_pc_write  = 1'b1;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        w_alu_op  = w_dec_alu_op;
        w_alu_src = w_dec_alu_src;
        case (w_cls)
          CLS_CBZ: begin
            w_branch   = 1'b1;
            w_pc_src   = aluZero;
            w_pc_write = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_B: begin
            w_uncond   = 1'b1;
            w_pc_src   = 1'b1;
            w_pc_write = 1'b1;
            state_d    = ST_FETCH;
          end
          CLS_LDUR, CLS_STUR: state_d = ST_MEMORY;
          CLS_RTYPE:          state_d = ST_WRITEBACK;
          default:            state_d = ST_FETCH;
        endcase
      end

      ST_MEMORY: begin
        // ALU controls stay applied so the computed address is stable for
        // the whole data access.
        w_alu_op  = w_dec_alu_op;
        w_alu_src = w_dec_alu_src;
        if (w_timeout) begin
          w_timeout_p = 1'b1;
          wait_d      = '0;
          state_d     = ST_FETCH;
        end else begin
          w_mem_read  = (w_cls == CLS_LDUR);
          w_mem_write = (w_cls == CLS_STUR);
          if (dmemAck) begin
            wait_d = '0;
            if (w_cls == CLS_LDUR) begin
              state_d = ST_WRITEBACK;
            end else begin
              w_pc_write = 1'b1;
              state_d    = ST_FETCH;
            end
          end else begin
            wait_d = w_wait_inc;
          end
        end
      end

      ST_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = (w_cls == CLS_LDUR);
        w_pc_write   = 1'b1;
        state_d      = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Stall freezes every register, which also discards a coincident ack.
    if (stall) begin
      state_d = state_q;
      ir_d    = ir_q;
      wait_d  = wait_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      wait_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      run_q   <= 1'b1;
    end
  end

  // Level outputs follow the (held) state; pulse outputs are suppressed
  // while stalled and so fire in the first unstalled cycle.
  assign imemReq             = w_imem_req;
  assign memRead             = w_mem_read;
  assign memWrite            = w_mem_write;
  assign memToReg            = w_mem_to_reg;
  assign branch              = w_branch;
  assign unconditionalBranch = w_uncond;
  assign pcSrc               = w_pc_src;
  assign aluOP               = w_alu_op;
  assign aluSRC              = w_alu_src;
  assign regWrite            = w_reg_write & ~stall;
  assign pcWrite             = w_pc_write  & ~stall;
  assign illegalOp           = w_illegal_p & ~stall;
  assign timeoutErr          = w_timeout_p & ~stall;

  assign reg2LocOut    = w_reg2loc;
  assign readRegister1 = ir_q[5 +: REG_ADDR_W];
  assign readRegister2 = w_reg2loc ? ir_q[0 +: REG_ADDR_W] : ir_q[16 +: REG_ADDR_W];
  assign writeRegister = ir_q[0 +: REG_ADDR_W];

endmodule
`default_nettype wire
